// File: rtl/ysyx_25040101_imm_pack_if.sv
// Request/response bus for the immediate packer.
// Request side: valid/ready with immediate, immediate format and base instruction.
// Response side: valid/ready with the packed instruction and its error flag.
interface ysyx_25040101_imm_pack_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  imm_src_i;
  logic [31:0] imm_i;
  logic [31:0] base_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic        err_o;

  modport master (
    output in_valid_i, imm_src_i, imm_i, base_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, err_o
  );

  modport slave (
    input  in_valid_i, imm_src_i, imm_i, base_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, err_o
  );
endinterface

// File: rtl/ysyx_25040101_imm_pack.sv
// Immediate packer: scatters an immediate (extender convention, B/J as halfword
// offsets, U unshifted) into a base RISC-V instruction word. The result goes
// through a 2-entry output FIFO, so an accepted request is visible one cycle later.
// Optional macro IMM_RANGE_CHECK_EN: flag immediates that do not fit the format and
// unsupported imm_src codes on err_o. Without it err_o is constant 0.
module ysyx_25040101_imm_pack #(
  parameter int DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  ysyx_25040101_imm_pack_if.slave       bus
);

  localparam logic [2:0] SRC_I = 3'b001;
  localparam logic [2:0] SRC_S = 3'b010;
  localparam logic [2:0] SRC_B = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;
  localparam logic [2:0] SRC_J = 3'b101;

  // Place the immediate bits into the format's fields; everything else is base.
  function automatic logic [31:0] pack_imm(input logic [2:0] src,
                                           input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] r;
    r = base;
    case (src)
      SRC_I: r[31:20] = imm[11:0];
      SRC_S: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      SRC_B: begin
        r[31]    = imm[11];
        r[7]     = imm[10];
        r[30:25] = imm[9:4];
        r[11:8]  = imm[3:0];
      end
      SRC_U: r[31:12] = imm[19:0];
      SRC_J: begin
        r[31]    = imm[19];
        r[19:12] = imm[18:11];
        r[20]    = imm[10];
        r[30:21] = imm[9:0];
      end
      default: r = base;
    endcase
    return r;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  // The upper bits must be a pure sign extension of the field's top bit.
  function automatic logic imm_err(input logic [2:0] src, input logic [31:0] imm);
    logic e;
    case (src)
      SRC_I, SRC_S, SRC_B: e = !((&imm[31:11]) || (~|imm[31:11]));
      SRC_U, SRC_J:        e = !((&imm[31:19]) || (~|imm[31:19]));
      default:             e = 1'b1;
    endcase
    return e;
  endfunction
`endif

  logic        push, pop;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic        in_ready_q;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] last_inst_q;

  // Handshakes and next occupancy.
  always_comb begin
    push  = bus.in_valid_i && in_ready_q;
    pop   = (cnt_q != 2'd0) && bus.out_ready_i;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control: occupancy, pointers (modulo 2) and registered ready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != 2'd2);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Entry storage; no reset needed since unread slots are never shown.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= pack_imm(bus.imm_src_i, bus.imm_i, bus.base_i);
  end

  // Remember the last delivered instruction so inst_o holds it while empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  last_inst_q <= 32'd0;
    else if (pop)  last_inst_q <= mem_q[rd_ptr_q];
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_mem_q [DEPTH];
  logic last_err_q;

  // Error flag captured alongside each entry.
  always_ff @(posedge clk_i) begin
    if (push) err_mem_q[wr_ptr_q] <= imm_err(bus.imm_src_i, bus.imm_i);
  end

  // Last delivered error flag, shown while empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_err_q <= 1'b0;
    else if (pop) last_err_q <= err_mem_q[rd_ptr_q];
  end

  assign bus.err_o = (cnt_q != 2'd0) ? err_mem_q[rd_ptr_q] : last_err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = (cnt_q != 2'd0);
  assign bus.inst_o      = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : last_inst_q;

endmodule
